// File: rtl/subtree_response_merger.sv
// Merges child response words into one upstream stream: round-robin grant, small output FIFO,
// source-index tagging and a saturating count of words accepted upstream.
module subtree_response_merger #(
   parameter int unsigned NUM_CHILDREN = 5,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned IDX_W        = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CHILDREN-1:0]        child_valid,
   input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
   output logic [NUM_CHILDREN-1:0]        child_ready,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [IDX_W-1:0]               out_src,
   input  logic                           out_ready,
   output logic [15:0]                    fwd_count,
   output logic                           idle
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned EntW = IDX_W + DATA_W;

   logic [EntW-1:0]         mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]         count_q;
   logic [IDX_W-1:0]        rr_ptr_q;
   logic [15:0]             fwd_count_q;

   logic                    empty, full, push, pop;
   logic [NUM_CHILDREN-1:0] grant;
   logic [IDX_W-1:0]        grant_idx;
   logic [DATA_W-1:0]       grant_data;
   logic [EntW-1:0]         head;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(FIFO_DEPTH));

   // Two passes give the wrapped search: children at or above rr_ptr first, then the rest.
   always_comb begin
      grant      = '0;
      grant_idx  = '0;
      grant_data = '0;
      if (rst_n && !full) begin
         for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (grant == '0 && child_valid[i] && IDX_W'(i) >= rr_ptr_q) begin
               grant[i]   = 1'b1;
               grant_idx  = IDX_W'(i);
               grant_data = child_data[i*DATA_W +: DATA_W];
            end
         end
         for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (grant == '0 && child_valid[i] && IDX_W'(i) < rr_ptr_q) begin
               grant[i]   = 1'b1;
               grant_idx  = IDX_W'(i);
               grant_data = child_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign push        = |grant;
   assign child_ready = grant;
   assign out_valid   = rst_n && !empty;
   assign pop         = out_valid && out_ready;
   assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_data    = head[DATA_W-1:0];
   assign out_src     = head[EntW-1:DATA_W];
   assign fwd_count   = fwd_count_q;
   assign idle        = empty && (child_valid == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rr_ptr_q    <= '0;
         fwd_count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
            rr_ptr_q <= (grant_idx == IDX_W'(NUM_CHILDREN - 1)) ? '0 : grant_idx + IDX_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (fwd_count_q != 16'hFFFF) begin
               fwd_count_q <= fwd_count_q + 16'd1;
            end
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (!push && pop) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {grant_idx, grant_data};
      end
   end

endmodule

// File: doc/subtree_response_merger.md
Name: subtree_response_merger

Overview:
- Fan-in counterpart to the per-level instance fan-out of the generated module tree: merges response words returning from NUM_CHILDREN child instances into one upstream stream toward the parent level.
- Round-robin arbitration across children with valid/ready handshakes, followed by a small output FIFO.
- Tags every word with its source child index and keeps a saturating count of forwarded words.

Parameters:
- NUM_CHILDREN, 5: number of child response ports (2..8).
- DATA_W, 16: response word width.
- FIFO_DEPTH, 4: output FIFO entries (power of 2, >=2).
- IDX_W, 3: width of the source index; must satisfy 2^IDX_W >= NUM_CHILDREN.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- child_valid  in  NUM_CHILDREN  per-child word valid.
- child_data  in  NUM_CHILDREN*DATA_W  child i occupies bits [i*DATA_W +: DATA_W].
- child_ready  out  NUM_CHILDREN  one-hot-or-zero grant/accept.
- out_valid  out  1  FIFO head valid.
- out_data  out  DATA_W  FIFO head word.
- out_src  out  IDX_W  child index of the head word.
- out_ready  in  1  upstream accept.
- fwd_count  out  16  number of words accepted upstream, saturating.
- idle  out  1  FIFO empty and no child_valid asserted.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - child_ready=0, out_valid=0, out_data=0, out_src=0, fwd_count=0.
  - FIFO pointers cleared; round-robin pointer = 0.
  - Reset mid-transfer discards all FIFO contents with no partial output.
- child_ready is combinational from the registered state and child_valid:
  - When the FIFO is not full, exactly one child_ready is asserted: the first requesting child, searching from rr_ptr upward with wrap at NUM_CHILDREN-1 -> 0.
  - When the FIFO is full, or no child is valid, child_ready = 0.
- Child-side transfer occurs when child_valid[i] && child_ready[i]:
  - {i, child_data[i]} is written to the FIFO tail at that edge.
  - rr_ptr <= (i+1) mod NUM_CHILDREN.
  - rr_ptr is unchanged on cycles with no transfer.
- Upstream:
  - out_valid = FIFO not empty; out_data and out_src come from the head entry.
  - Pop on out_valid && out_ready.
  - Latency: a word accepted from a child at edge N is visible on the outputs after edge N when the FIFO was empty (one-cycle latency).
- Full/simultaneous events:
  - Full is computed from registered occupancy. Writes are blocked when full even if a pop happens in the same cycle (no write-through at full).
  - Push and pop in the same cycle leave occupancy unchanged.
  - Push when empty and pop are never simultaneous on the same entry: out_valid was 0 that cycle.
- fwd_count increments by 1 on every upstream pop and holds at 16'hFFFF.
- idle = (occupancy==0) && (child_valid==0).
- Children must hold child_valid/child_data stable until accepted; a child that drops valid without a grant simply loses its turn, with no error.
- No data is ever dropped: occupancy never exceeds FIFO_DEPTH.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while all child_valid=1 -> child_ready=0, out_valid=0, fwd_count=0, idle=0. First grant after release goes to child 0.
- Fairness: all 5 children continuously valid with data 16'h0i00+k, out_ready=1 -> out_src sequence 0,1,2,3,4,0,1,... and each child gets exactly 1 grant per 5 cycles.
- Backpressure: out_ready=0 and children 1 and 3 valid -> 4 words accepted (1,3,1,3), then child_ready=0. Raise out_ready -> words emerge in that order, then granting resumes.
- Wrap: rr_ptr=4 (last grant to child 3), only child 0 and child 4 valid -> child 4 granted first, then child 0.
- Saturation: force 65540 upstream pops -> fwd_count stops at 16'hFFFF.
- Reset mid-operation: FIFO holding 3 entries, assert rst_n=0 for 1 cycle -> out_valid=0 the next cycle, occupancy 0, and none of the 3 words are ever emitted.
